// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//   8-bit SPI slave, SPI mode 0 (CPOL=0, CPHA=0), MSB first. All SPI pins are
//   oversampled in the sys_clk domain. One byte of TX buffering sits in front
//   of the transmit shift register.
//
// Ports
//   sys_clk      in   system clock (50 MHz)
//   sys_rst_n    in   asynchronous reset, active low
//   spi_sclk     in   SPI clock from master (asynchronous)
//   spi_cs       in   chip select, active low (asynchronous)
//   spi_mosi     in   serial data from master (asynchronous)
//   spi_miso     out  serial data to master, 0 while idle
//   tx_data      in   [7:0] next byte to send
//   tx_load      in   strobe, writes tx_data into the TX buffer when tx_ready
//   tx_ready     out  TX buffer empty
//   rx_data      out  [7:0] last complete byte received
//   rx_valid     out  one-cycle pulse, rx_data updated
//   tx_underrun  out  one-cycle pulse, a byte was taken from an empty buffer
//   busy         out  synchronized chip select is active
// -----------------------------------------------------------------------------
module spi_slave (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       spi_sclk,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun,
  output logic       busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Synchronizer chains: [0] = stage 1, [1] = stage 2, [2] = edge-detect stage
  logic [2:0] sclk_sync_q;
  logic [2:0] cs_sync_q;
  logic [2:0] mosi_sync_q;

  // Tracks that stage 2 holds real pin samples after reset release
  logic [1:0] sync_vld_q;
  logic       armed_q;

  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic       byte_done_q;
  logic [6:0] rx_shift_q;
  logic [6:0] tx_shift_q;   // bits still to be sent after the one on miso
  logic [7:0] tx_buf_q;
  logic       tx_ready_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       tx_underrun_q;
  logic       miso_q;

  logic       cs_fall;
  logic       cs_rise;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       mosi_bit;
  logic       start_evt;
  logic       reload_evt;
  logic       load_evt;
  logic [7:0] load_byte_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 3'b000;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[1:0], spi_cs};
      mosi_sync_q <= {mosi_sync_q[1:0], spi_mosi};
    end
  end

  assign cs_fall   = ~cs_sync_q[1] &  cs_sync_q[2];
  assign cs_rise   =  cs_sync_q[1] & ~cs_sync_q[2];
  // sclk edges only count while the synchronized chip select is low
  assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2] & ~cs_sync_q[1];
  assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2] & ~cs_sync_q[1];
  // mosi taken from the sample aligned with sclk's pre-rise level, so the
  // bit the master set up before the edge is the one captured
  assign mosi_bit  = mosi_sync_q[2];

  assign start_evt   = (state_q == IDLE) & cs_fall & armed_q;
  assign reload_evt  = (state_q == ACTIVE) & sclk_fall & byte_done_q;
  assign load_evt    = start_evt | reload_evt;
  assign load_byte_d = tx_ready_q ? 8'h00 : tx_buf_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_vld_q    <= 2'b00;
      armed_q       <= 1'b0;
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      byte_done_q   <= 1'b0;
      rx_shift_q    <= 7'd0;
      tx_shift_q    <= 7'd0;
      tx_buf_q      <= 8'h00;
      tx_ready_q    <= 1'b1;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      miso_q        <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;

      // A frame may only start from a cs fall that follows a genuinely
      // sampled high level, so a cs held low through reset is not a start.
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      if (sync_vld_q[1] && cs_sync_q[1]) begin
        armed_q <= 1'b1;
      end

      // Buffer hand-off to the shift register. A load from an empty buffer
      // sends 0x00; a tx_load in that same cycle still lands in the buffer.
      if (load_evt) begin
        if (tx_ready_q) begin
          tx_underrun_q <= 1'b1;
        end else begin
          tx_ready_q <= 1'b1;
        end
      end
      if (tx_load && tx_ready_q) begin
        tx_buf_q   <= tx_data;
        tx_ready_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          if (start_evt) begin
            state_q     <= ACTIVE;
            bit_cnt_q   <= 3'd0;
            byte_done_q <= 1'b0;
            rx_shift_q  <= 7'd0;
            tx_shift_q  <= load_byte_d[6:0];
            miso_q      <= load_byte_d[7];
          end
        end

        ACTIVE: begin
          if (cs_rise) begin
            // Abort or end of frame: drop any partial byte, keep the buffer
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            byte_done_q <= 1'b0;
            rx_shift_q  <= 7'd0;
            tx_shift_q  <= 7'd0;
            miso_q      <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift_q <= {rx_shift_q[5:0], mosi_bit};
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_q   <= {rx_shift_q, mosi_bit};
              rx_valid_q  <= 1'b1;
              byte_done_q <= 1'b1;
            end
          end else if (sclk_fall) begin
            if (byte_done_q) begin
              tx_shift_q  <= load_byte_d[6:0];
              miso_q      <= load_byte_d[7];
              byte_done_q <= 1'b0;
            end else begin
              tx_shift_q <= {tx_shift_q[5:0], 1'b0};
              miso_q     <= tx_shift_q[6];
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_miso    = miso_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign busy        = ~cs_sync_q[1];

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//   Directed bench for spi_slave. Stimulus pushes expected rx bytes and
//   expected miso bytes into queues; a monitor on the falling sys_clk edge
//   pops and compares whenever rx_valid pulses or the master model hands in
//   a captured miso byte. sclk runs at sys_clk/8.
// -----------------------------------------------------------------------------
module tb_spi_slave;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       spi_sclk  = 1'b0;
  logic       spi_cs    = 1'b1;
  logic       spi_mosi  = 1'b0;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_load   = 1'b0;
  logic       spi_miso;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       busy;

  int n_checks   = 0;
  int n_fail     = 0;
  int n_underrun = 0;

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_miso_q[$];
  logic [7:0] obs_miso_q[$];

  spi_slave dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .spi_sclk   (spi_sclk),
    .spi_cs     (spi_cs),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_underrun(tx_underrun),
    .busy       (busy)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Scoreboard monitor
  always @(negedge sys_clk) begin
    if (tx_underrun === 1'b1) n_underrun++;
    if (rx_valid === 1'b1) begin
      if (exp_rx_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_valid unexpected: got pulse with rx_data=0x%02h, expected none", rx_data);
      end else begin
        check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
      end
    end
    if (obs_miso_q.size() != 0) begin
      if (exp_miso_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL miso byte unexpected: got 0x%02h, expected none", obs_miso_q.pop_front());
      end else begin
        check("miso byte", {24'd0, obs_miso_q.pop_front()}, {24'd0, exp_miso_q.pop_front()});
      end
    end
  end

  task automatic load(input logic [7:0] d);
    @(negedge sys_clk);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge sys_clk);
    tx_load = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int cyc;
    cyc = 0;
    while (tx_ready !== 1'b1 && cyc < 40) begin
      @(negedge sys_clk);
      cyc++;
    end
    check(name, {31'd0, tx_ready}, 32'd1);
  endtask

  task automatic cs_low();
    @(negedge sys_clk);
    spi_cs = 1'b0;
    repeat (6) @(negedge sys_clk);
  endtask

  task automatic cs_high();
    @(negedge sys_clk);
    spi_cs = 1'b1;
    repeat (6) @(negedge sys_clk);
  endtask

  // Mode-0 master: mosi set while sclk low, miso sampled on the rising edge
  task automatic xfer(input logic [7:0] mosi_b, input int nbits, output logic [7:0] miso_b);
    miso_b = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = mosi_b[i];
      repeat (4) @(negedge sys_clk);
      spi_sclk  = 1'b1;
      miso_b[i] = spi_miso;
      repeat (4) @(negedge sys_clk);
      spi_sclk = 1'b0;
    end
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic send_byte(input logic [7:0] mosi_b, input logic [7:0] exp_miso);
    logic [7:0] got;
    exp_rx_q.push_back(mosi_b);
    exp_miso_q.push_back(exp_miso);
    xfer(mosi_b, 8, got);
    obs_miso_q.push_back(got);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int u;
    logic [7:0] part;

    // Reset state
    #5 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("reset spi_miso", {31'd0, spi_miso}, 32'd0);
    check("reset rx_data", {24'd0, rx_data}, 32'h00);
    check("reset rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset tx_underrun", {31'd0, tx_underrun}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset tx_ready", {31'd0, tx_ready}, 32'd1);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);

    // S1: single byte, 0xA5 out, 0x3C in
    u = n_underrun;
    load(8'hA5);
    check("s1 tx_ready after load", {31'd0, tx_ready}, 32'd0);
    cs_low();
    check("s1 busy after cs fall", {31'd0, busy}, 32'd1);
    check("s1 tx_ready at cs fall", {31'd0, tx_ready}, 32'd1);
    send_byte(8'h3C, 8'hA5);
    cs_high();
    // final falling edge pulls from the now-empty buffer
    check("s1 underrun count", n_underrun - u, 32'd1);

    // S2: back-to-back 0x81, 0x7E, filler keeps the last fall fed
    u = n_underrun;
    load(8'h81);
    cs_low();
    wait_ready("s2 ready after first load");
    load(8'h7E);
    send_byte(8'h12, 8'h81);
    wait_ready("s2 ready after byte 1");
    load(8'h55);
    send_byte(8'h34, 8'h7E);
    cs_high();
    check("s2 underrun count", n_underrun - u, 32'd0);

    // S3: empty buffer at cs fall
    u = n_underrun;
    cs_low();
    check("s3 underrun at cs fall", n_underrun - u, 32'd1);
    send_byte(8'h96, 8'h00);
    cs_high();
    check("s3 underrun count", n_underrun - u, 32'd2);

    // S4: cs raised after 5 bits; buffered byte survives the abort
    u = n_underrun;
    load(8'hE7);
    cs_low();
    load(8'h3A);
    xfer(8'hB5, 5, part);
    check("s4 partial miso bits", {24'd0, part}, 32'hE0);
    @(negedge sys_clk);
    spi_cs = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("s4 busy after cs rise", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge sys_clk);
    check("s4 buffer kept", {31'd0, tx_ready}, 32'd0);
    cs_low();
    send_byte(8'h5B, 8'h3A);
    cs_high();
    check("s4 underrun count", n_underrun - u, 32'd1);

    // S5: tx_load while full is ignored
    u = n_underrun;
    load(8'hC3);
    load(8'hFF);
    check("s5 tx_ready stays 0", {31'd0, tx_ready}, 32'd0);
    cs_low();
    send_byte(8'hA1, 8'hC3);
    cs_high();
    check("s5 underrun count", n_underrun - u, 32'd1);

    // S6: reset after 4 bits; no restart until cs high then low
    load(8'h99);
    cs_low();
    xfer(8'hF0, 4, part);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("s6 reset spi_miso", {31'd0, spi_miso}, 32'd0);
    check("s6 reset rx_data", {24'd0, rx_data}, 32'h00);
    check("s6 reset rx_valid", {31'd0, rx_valid}, 32'd0);
    check("s6 reset tx_underrun", {31'd0, tx_underrun}, 32'd0);
    check("s6 reset busy", {31'd0, busy}, 32'd0);
    check("s6 reset tx_ready", {31'd0, tx_ready}, 32'd1);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    u = n_underrun;
    xfer(8'hFF, 8, part);
    check("s6 miso idle while cs held low", {24'd0, part}, 32'h00);
    check("s6 no start without fresh cs fall", n_underrun - u, 32'd0);
    cs_high();
    load(8'h6D);
    cs_low();
    send_byte(8'hD2, 8'h6D);
    cs_high();
    check("s6 underrun count", n_underrun - u, 32'd1);

    repeat (4) @(negedge sys_clk);
    check("rx scoreboard drained", exp_rx_q.size(), 32'd0);
    check("miso scoreboard drained", exp_miso_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have no parameters; the frame is fixed at 8 bits, MSB first, SPI mode 0 (CPOL=0, CPHA=0).
REQ-003 sys_clk  input  1  system clock, 50 MHz.
REQ-004 sys_rst_n  input  1  asynchronous reset, active low.
REQ-005 spi_sclk  input  1  SPI clock from the master, asynchronous to sys_clk.
REQ-006 spi_cs  input  1  chip select from the master, active low, asynchronous.
REQ-007 spi_mosi  input  1  serial data from the master, asynchronous.
REQ-008 spi_miso  output  1  serial data to the master.
REQ-009 tx_data  input  8  next byte to send to the master.
REQ-010 tx_load  input  1  single-cycle strobe that writes tx_data into the TX buffer.
REQ-011 tx_ready  output  1  TX buffer empty; tx_load is accepted.
REQ-012 rx_data  output  8  last complete byte received from the master.
REQ-013 rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-014 tx_underrun  output  1  one-cycle pulse, a byte was consumed from an empty TX buffer.
REQ-015 busy  output  1  synchronized chip select is active (low).

Function
REQ-016 spi_sclk, spi_cs and spi_mosi SHALL each pass through a 2-flop synchronizer, followed by a third flop used for edge detection.
REQ-017 A rising or falling event SHALL be the synchronized-stage-2 value differing from stage 3; sclk events SHALL be ignored while synchronized cs is high.
REQ-018 Timing: an internal event SHALL act on the 3rd sys_clk edge after the first edge that samples the new pin level. Supported spi_sclk is at most sys_clk/8, each level held at least 4 sys_clk.
REQ-019 States SHALL be IDLE (cs high) and ACTIVE (cs low).
REQ-020 IDLE->ACTIVE SHALL occur on a cs falling event: clear bit_cnt, load the shift register from the TX buffer, and drive spi_miso = bit 7.
REQ-021 ACTIVE->IDLE SHALL occur on a cs rising event from any bit_cnt.
REQ-022 Receive: on each sclk rising event in ACTIVE, shift synchronized mosi into the RX shift register LSB, and increment bit_cnt (0..7, wrapping 7->0).
REQ-023 On the rising event with bit_cnt==7, the block SHALL, in the same cycle:
- write rx_data with the completed byte;
- pulse rx_valid for exactly 1 sys_clk;
- set the byte_done flag.
REQ-024 Transmit, on each sclk falling event in ACTIVE:
- if byte_done is set: load a new byte from the TX buffer, drive its bit 7, and clear byte_done;
- otherwise: shift left and drive the next bit.
REQ-025 Buffer load (REQ-020, REQ-024):
- buffer full: move the byte to the shift register and set tx_ready=1;
- buffer empty: load 0x00 and pulse tx_underrun for 1 cycle.
REQ-026 tx_load with tx_ready=1 SHALL write the buffer and clear tx_ready on the next edge; tx_load with tx_ready=0 SHALL be ignored, and the buffer is unchanged.
REQ-027 tx_load in the same cycle as a load from an empty buffer SHALL give underrun (0x00 sent), and tx_data SHALL be kept in the buffer for the following byte.
REQ-028 cs rising mid-byte SHALL discard the partial RX byte (no rx_valid), discard the shift register, clear bit_cnt and byte_done, and keep the TX buffer.
REQ-029 A byte loaded at the final boundary falling edge before cs rises SHALL count as consumed.
REQ-030 spi_miso SHALL be 0 in IDLE.
REQ-031 busy SHALL equal the inverted synchronized cs (stage 2).

Reset
REQ-032 Asserting sys_rst_n=0 SHALL immediately set:
- spi_miso=0, rx_data=0x00, rx_valid=0, tx_underrun=0, busy=0, tx_ready=1;
- state=IDLE, bit_cnt=0, byte_done=0;
- all synchronizer flops to cs=1, sclk=0, mosi=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame.
REQ-034 After reset release, the block SHALL wait for a fresh cs falling event; it SHALL NOT start while cs is already low.

Verification
REQ-035 The bench SHALL cover these directed scenarios (sclk = sys_clk/8):
- Load 0xA5, master sends 0x3C -> master samples 0xA5 on miso; rx_data=0x3C with one rx_valid pulse; tx_ready returns to 1 at cs fall.
- Two back-to-back bytes, buffer 0x81 then 0x7E (loaded after tx_ready) -> miso 0x81,0x7E; two rx_valid pulses; no underrun.
- No tx_load before cs fall -> tx_underrun pulse at cs fall; miso sends 0x00; the received byte is still valid.
- cs raised after 5 bits -> no rx_valid; busy=0 within 3 cycles; next frame receives cleanly from bit 7.
- tx_load=1 while tx_ready=0 with 0xFF -> ignored; the original buffered byte is transmitted.
- sys_rst_n asserted after 4 bits -> all outputs at reset values; frame restarts only after cs high-then-low.
